// File: rtl/pc_sequencer.sv
// Instruction-fetch and next-PC controller for the MIPS core.
// Runs a fetch/execute handshake with imem and selects the next PC on resolve.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        resolve_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] retire_cnt,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retire_cnt;
    logic        r_instr_valid;
    logic        r_align_err;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_retire_nxt;
    logic        w_valid_nxt;
    logic        w_align_nxt;
    logic        w_req;

    logic [31:0] w_pc4;
    logic [31:0] w_boff;
    logic [31:0] w_btgt;
    logic [31:0] w_jtgt;
    logic [31:0] w_rtgt;
    logic [31:0] w_target;

    assign w_pc4  = r_pc + 32'd4;
    assign w_boff = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_btgt = w_pc4 + w_boff;
    assign w_jtgt = {w_pc4[31:28], r_instr[25:0], 2'b00};
    assign w_rtgt = {rs_val[31:2], 2'b00};

    // Redirect priority: jr over jump over taken branch over sequential.
    always_comb begin
        w_target = w_pc4;
        if (jr) begin
            w_target = w_rtgt;
        end else if (jump) begin
            w_target = w_jtgt;
        end else if (branch_taken) begin
            w_target = w_btgt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_retire_cnt  <= 32'd0;
            r_align_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_valid_nxt;
            r_retire_cnt  <= w_retire_nxt;
            r_align_err   <= w_align_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_valid_nxt  = r_instr_valid;
        w_retire_nxt = r_retire_cnt;
        w_align_nxt  = r_align_err;
        w_req        = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                w_req = 1'b1;
                if (imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (resolve_valid && !stall) begin
                    w_pc_nxt     = w_target;
                    w_retire_nxt = r_retire_cnt + 32'd1;
                    w_valid_nxt  = 1'b0;
                    w_state_nxt  = FETCH;
                    if (jr && (rs_val[1:0] != 2'b00)) begin
                        w_align_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign retire_cnt  = r_retire_cnt;
    assign align_err   = r_align_err;

endmodule
